// File: rtl/serial_shift_unit_if.sv
// Operand/result bundle between the execute-stage control and serial_shift_unit.
// The master drives the request; the slave (the shifter) returns the result and status.
interface serial_shift_unit_if #(
    parameter int size = 32
);
    logic            start;
    logic [size-1:0] A;
    logic [size-1:0] B;
    logic [1:0]      Sel;
    logic [size-1:0] S;
    logic            busy;
    logic            done;

    modport master (
        output start, A, B, Sel,
        input  S, busy, done
    );

    modport slave (
        input  start, A, B, Sel,
        output S, busy, done
    );
endinterface

// File: rtl/serial_shift_unit.sv
// Multi-cycle SLL/SRL/SRA unit with a start/busy/done handshake.
// Define SHIFT_MULTI_STEP_EN to shift by 4 per cycle while at least 4 positions remain.
module serial_shift_unit #(
    parameter int size = 32
) (
    input logic               clk,
    input logic               reset,
    serial_shift_unit_if.slave bus
);
    localparam int CW = $clog2(size);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state, state_next;
    logic [size-1:0] acc, acc_next;
    logic [size-1:0] s_reg;
    logic [CW-1:0]   cnt, cnt_next;
    logic [1:0]      op, op_next;
    logic [CW-1:0]   shamt;
    logic            step4;
    logic            unused_b;

    assign shamt    = bus.B[CW-1:0];
    assign unused_b = ^bus.B[size-1:CW];

`ifdef SHIFT_MULTI_STEP_EN
    // Extra top bit keeps the ">= 4" test meaningful even when CW is only 2.
    assign step4 = ({1'b0, cnt} >= (CW+1)'(4));
`else
    assign step4 = 1'b0;
`endif

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        op_next    = op;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    acc_next = (bus.Sel == 2'b11) ? '0 : bus.A;
                    cnt_next = shamt;
                    op_next  = bus.Sel;
                    state_next = (shamt != '0 && bus.Sel != 2'b11) ? SHIFT : DONE;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                case (op)
                    2'b00:   acc_next = step4 ? (acc << 4) : (acc << 1);
                    2'b01:   acc_next = step4 ? (acc >> 4) : (acc >> 1);
                    2'b10:   acc_next = step4 ? $unsigned($signed(acc) >>> 4)
                                              : $unsigned($signed(acc) >>> 1);
                    default: acc_next = '0;
                endcase
                cnt_next = step4 ? (cnt - CW'(4)) : (cnt - CW'(1));
                if (cnt_next == '0) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The result register only loads on the way into DONE, so S holds steady through IDLE and SHIFT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            op    <= '0;
            s_reg <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            op    <= op_next;
            if (state_next == DONE) begin
                s_reg <= acc_next;
            end
        end
    end

    assign bus.S    = s_reg;
    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed self-checking bench for serial_shift_unit; latency expectations follow
// whichever build (SHIFT_MULTI_STEP_EN defined or not) is compiled.
module tb_serial_shift_unit;
    logic clk;
    logic reset;
    int   checks;
    int   passed;

    serial_shift_unit_if #(.size(32)) bus ();

    serial_shift_unit #(.size(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle in which done is expected for shift amount n, counting the accept edge as 0.
    function automatic int lat(input int n);
`ifdef SHIFT_MULTI_STEP_EN
        return n / 4 + n % 4 + 1;
`else
        return n + 1;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Presents one request for a single cycle; returns at the falling edge of cycle 1.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.Sel   = sel;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = 32'hDEAD_BEEF;
        bus.B     = 32'h0000_001F;
        bus.Sel   = 2'b11;
    endtask

    task automatic waitDone(input int first, output int cyc, output int busy_n);
        cyc    = first;
        busy_n = 0;
        while (bus.done !== 1'b1 && cyc < 300) begin
            if (bus.busy === 1'b1) busy_n++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] sel, input logic [31:0] exp_s,
                         input int exp_cyc, input int exp_busy);
        int cyc;
        int busy_n;
        applyStimulus(a, b, sel);
        waitDone(1, cyc, busy_n);
        checkOutput({tag, "_latency"}, cyc, exp_cyc);
        checkOutput({tag, "_S"}, bus.S, exp_s);
        checkOutput({tag, "_busy_cycles"}, busy_n, exp_busy);
        @(negedge clk);
        checkOutput({tag, "_done_single"}, {31'b0, bus.done}, 32'd0);
        checkOutput({tag, "_S_hold"}, bus.S, exp_s);
    endtask

    initial begin
        int cyc;
        int busy_n;
        int spurious;
        checks    = 0;
        passed    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Sel   = 2'b00;
        repeat (2) @(negedge clk);
        checkOutput("reset_S", bus.S, 32'd0);
        checkOutput("reset_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("reset_done", {31'b0, bus.done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        runOp("sll31", 32'h0000_0001, 32'd31, 2'b00, 32'h8000_0000, lat(31), lat(31) - 1);
        runOp("sra4",  32'h8000_00F0, 32'd4,  2'b10, 32'hF800_000F, lat(4), lat(4) - 1);
        runOp("srl4",  32'h8000_00F0, 32'd4,  2'b01, 32'h0800_000F, lat(4), lat(4) - 1);
        runOp("zero",  32'h1234_5678, 32'd0,  2'b00, 32'h1234_5678, 1, 0);
        runOp("rsvd",  32'hFFFF_FFFF, 32'd5,  2'b11, 32'h0000_0000, 1, 0);
        runOp("hi_b",  32'h0000_00F0, 32'hFFFF_FFE3, 2'b00, 32'h0000_0780, lat(3), lat(3) - 1);
        runOp("sra31", 32'h8000_0000, 32'd31, 2'b10, 32'hFFFF_FFFF, lat(31), lat(31) - 1);
        runOp("srl5",  32'h0000_0040, 32'd5,  2'b01, 32'h0000_0002, lat(5), lat(5) - 1);

        // Start pulse and operand changes while busy must not disturb the running shift.
        applyStimulus(32'hFF00_0000, 32'd8, 2'b01);
        bus.start = 1'b1;
        bus.A     = 32'h0000_0001;
        bus.B     = 32'd1;
        bus.Sel   = 2'b00;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(2, cyc, busy_n);
        checkOutput("ignore_latency", cyc, lat(8));
        checkOutput("ignore_S", bus.S, 32'h00FF_0000);

        // Back-to-back: the second request is accepted in the first one's DONE cycle.
        @(negedge clk);
        applyStimulus(32'h0000_0005, 32'd1, 2'b00);
        waitDone(1, cyc, busy_n);
        checkOutput("b2b_first_S", bus.S, 32'h0000_000A);
        applyStimulus(32'h0000_0003, 32'd2, 2'b00);
        checkOutput("b2b_no_bubble", {31'b0, bus.busy}, 32'd1);
        waitDone(1, cyc, busy_n);
        checkOutput("b2b_latency", cyc, 3);
        checkOutput("b2b_S", bus.S, 32'h0000_000C);
        @(negedge clk);

        // Reset in the middle of a long shift.
        applyStimulus(32'hFFFF_FFFF, 32'd20, 2'b01);
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort_busy_before", {31'b0, bus.busy}, 32'd1);
        reset    = 1'b1;
        spurious = 0;
        @(negedge clk);
        checkOutput("abort_S", bus.S, 32'd0);
        checkOutput("abort_busy", {31'b0, bus.busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.done !== 1'b0) spurious++;
            @(negedge clk);
        end
        checkOutput("abort_no_done", spurious, 0);
        checkOutput("abort_S_after", bus.S, 32'd0);
        runOp("after_abort", 32'hFFFF_FFFF, 32'd20, 2'b01, 32'h0000_0FFF, lat(20), lat(20) - 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/serial_shift_unit.md
# serial_shift_unit

Multi-cycle shifter for the RV32I execute stage. It implements SLL, SRL and SRA by shifting one bit per cycle, with a start/done handshake in place of a combinational barrel shifter. It uses the same operand/select convention as the combinational logic path: A is the operand, the low bits of B are the shift amount, and a 2-bit Sel picks the operation. The pipeline hazard logic stalls on `busy`.

## Interface
- `size`, 32, operand/result width in bits; must be a power of two ≥ 4
- `clk` input 1: rising-edge clock
- `reset` input 1: synchronous, active-high; one clock, no other clock domains
- `start` input 1: request pulse; sampled only when `busy` = 0
- `A` input `size`: operand to shift
- `B` input `size`: shift amount in `B[$clog2(size)-1:0]`; upper bits ignored
- `Sel` input 2: 00 SLL, 01 SRL, 10 SRA, 11 reserved (result zero)
- `S` output `size`: result register
- `busy` output 1: high while the state is SHIFT
- `done` output 1: one-cycle pulse when `S` becomes valid

## Operation
- States are IDLE, SHIFT and DONE.
- **Reset:** state = IDLE, `S` = 0, `busy` = 0, `done` = 0. Internal accumulator, count and op registers are cleared.
- **Accept:**
  - `start` = 1 in IDLE or DONE captures `acc` ← A, `cnt` ← shamt, `op` ← Sel.
  - Next state is SHIFT if `cnt` ≠ 0 and `op` ≠ 11; otherwise DONE.
  - For `op` = 11, `acc` ← 0.
- **SHIFT (per cycle):**
  - SLL: `acc` ← {acc[size-2:0], 0}.
  - SRL: `acc` ← {0, acc[size-1:1]}.
  - SRA: `acc` ← {acc[size-1], acc[size-1:1]}.
  - `cnt` decrements each cycle; when it reaches 0, next state is DONE.
- **DONE:**
  - `S` ← `acc` and `done` = 1 for exactly this cycle.
  - Next state is IDLE, unless `start` = 1 (back-to-back accept, see Accept).
- `S` changes only on entry to DONE and holds its value through IDLE and SHIFT until the next DONE.
- `start` during SHIFT is ignored: no queueing, no error.
- A, B and Sel are don't-care except in the accept cycle. Mid-operation changes have no effect.
- Shift amounts above `size`-1 cannot occur: shamt is truncated to $clog2(size) bits.
- **Reset mid-operation:** aborts immediately to IDLE with `S` = 0, and no `done` pulse is produced.

## Timing
- `start` is accepted at edge 0 with shamt n.
- Baseline:
  - `busy` = 1 in cycles 1..n.
  - DONE with `done` = 1 and `S` valid in cycle n+1.
  - Latency is n+1 cycles; n = 0 gives 1 cycle.
- `busy` and `done` are registered state decodes, with no combinational path from `start`.
- Throughput: with `start` held high, a new operation is accepted in every DONE cycle. There is no idle bubble between operations.

## Configuration
- `SHIFT_MULTI_STEP_EN`
  - **Defined:** in SHIFT, if `cnt` ≥ 4 the unit shifts by 4 and `cnt` decreases by 4 (SRA fills with the sign bit); otherwise it shifts by 1. SHIFT occupancy becomes floor(n/4) + (n mod 4) cycles, and `done` occurs in the cycle after the last SHIFT cycle. Example: n = 31 gives 7 + 3 = 10 SHIFT cycles, with `done` in cycle 11.
  - **Undefined:** baseline 1-bit-per-cycle behaviour exactly as above.
- Results are identical in both builds; only latency differs.

## Test plan
- **Reset:** assert `reset` for 2 cycles mid-SHIFT (A = 0xFFFF_FFFF, SRL, n = 20) → `S` = 0, `busy` = 0, no `done` pulse; the next `start` operates normally.
- **SLL:** A = 0x0000_0001, Sel = 00, B = 31 → `busy` for 31 cycles, `done` in cycle 32, `S` = 0x8000_0000.
- **SRA vs SRL:** A = 0x8000_00F0, B = 4 → Sel = 10 gives `S` = 0xF800_000F; Sel = 01 gives `S` = 0x0800_000F. Both have `done` in cycle 5.
- **Zero shift and reserved op:**
  - A = 0x1234_5678, B = 0, Sel = 00 → `done` in cycle 1, `busy` never high, `S` = 0x1234_5678.
  - Sel = 11 → `done` in cycle 1, `S` = 0.
- **Handshake:**
  - `start` pulses and A/Sel changes during SHIFT are ignored and the result is unchanged.
  - `start` held high in the DONE cycle with A = 0x3, SLL, B = 2 → back-to-back accept, next `done` 3 cycles later with `S` = 0xC.
- **`SHIFT_MULTI_STEP_EN` build:** A = 0x8000_0000, SRA, B = 31 → `done` in cycle 11, `S` = 0xFFFF_FFFF. A B = 5 case → 2 SHIFT cycles.
